// File: rtl/shift_serializer_pkg.sv
// Shared definitions for the shift_serializer slice: FSM encoding and
// direction constants used by the top and its holding register.
package shift_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage : shift_serializer_pkg

// File: rtl/shift_serializer_reg.sv
// Generic loadable bidirectional shift register with synchronous clear.
// Priority: clear, then parallel load, then right shift, then left shift.
module shift_serializer_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_i,
    input  logic             cl_i,
    input  logic             sr_i,
    input  logic             sl_i,
    input  logic             ir_i,
    input  logic             il_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next contents: clear wins, load beats shifting, right shift beats left.
    always_comb begin
        q_d = q_q;
        if (cl_i) begin
            q_d = '0;
        end else if (ld_i) begin
            q_d = d_i;
        end else if (sr_i) begin
            q_d = {ir_i, q_q[WIDTH-1:1]};
        end else if (sl_i) begin
            q_d = {q_q[WIDTH-2:0], il_i};
        end
    end

    // Register the contents; async reset empties the register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule : shift_serializer_reg

// File: rtl/shift_serializer.sv
// Parallel-to-serial transmitter: accepts one word over valid/ready and
// drives it bit by bit, with a right or left shift strobe, into a remote
// shift register so that it holds the word after DATA_WIDTH strobes.
module shift_serializer
    import shift_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cl,
    input  logic [DATA_WIDTH-1:0] in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  dir,
    input  logic                  hold,
    output logic                  sbit,
    output logic                  sr,
    output logic                  sl,
    output logic                  busy,
    output logic                  done
);

    localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   dir_q, dir_d;
    logic                   accept;
    logic [DATA_WIDTH-1:0]  sh_q;

    // Next-state and output decode; an abort overrides whatever the state
    // would otherwise do and also suppresses the strobe of that cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        sr       = 1'b0;
        sl       = 1'b0;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = !cl;
                if (in_valid && !cl) begin
                    accept  = 1'b1;
                    dir_d   = dir;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (!hold && !cl) begin
                    sr    = (dir_q == DIR_RIGHT);
                    sl    = (dir_q == DIR_LEFT);
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (cl) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // Serial bit comes from whichever end of the word leaves first.
    always_comb begin
        sbit = 1'b0;
        if (state_q == SHIFT) begin
            sbit = (dir_q == DIR_LEFT) ? sh_q[DATA_WIDTH-1] : sh_q[0];
        end
    end

    // FSM state, bit counter and latched direction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= DIR_RIGHT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    // The word being sent shifts out with zeros filling the vacated end.
    shift_serializer_reg #(
        .WIDTH (DATA_WIDTH)
    ) u_sh (
        .clk   (clk),
        .rst_n (rst_n),
        .ld_i  (accept),
        .cl_i  (cl),
        .sr_i  (sr),
        .sl_i  (sl),
        .ir_i  (1'b0),
        .il_i  (1'b0),
        .d_i   (in),
        .q_o   (sh_q)
    );

endmodule : shift_serializer

// File: tb/tb_shift_serializer.sv
// Self-checking bench for shift_serializer with a loopback receiver model.
module tb_shift_serializer;

    logic        clk;
    logic        rst_n;
    logic        cl;
    logic [15:0] in;
    logic        in_valid;
    logic        in_ready;
    logic        dir;
    logic        hold;
    logic        sbit;
    logic        sr;
    logic        sl;
    logic        busy;
    logic        done;

    logic [15:0] rx;
    int          checks;
    int          fails;

    typedef struct {
        logic [15:0] word;
        logic        d;
        logic [15:0] expSeq;
        logic [15:0] expRx;
        string       name;
    } vec_t;

    vec_t vecs[5];

    shift_serializer #(
        .DATA_WIDTH (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cl       (cl),
        .in       (in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dir      (dir),
        .hold     (hold),
        .sbit     (sbit),
        .sr       (sr),
        .sl       (sl),
        .busy     (busy),
        .done     (done)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream receiver: shifts sbit in on each strobe, sampled mid-cycle.
    always @(negedge clk) begin
        if (sr) begin
            rx <= {sbit, rx[15:1]};
        end else if (sl) begin
            rx <= {rx[14:0], sbit};
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] w, input logic d, input logic v);
        in       = w;
        dir      = d;
        in_valid = v;
    endtask

    // One full transfer with optional hold window, checking every cycle.
    task automatic runTransfer(input logic [15:0] word, input logic d, input int holdAt,
                               input int holdLen, input logic [15:0] expSeq,
                               input logic [15:0] expRx, input string name);
        int   idx;
        int   cyc;
        int   held;
        logic prevSbit;
        bit   gotDone;
        @(posedge clk); #1;
        applyStimulus(word, d, 1'b1);
        @(negedge clk);
        checkOutput({name, " ready_before"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1; idx = 0; held = 0; gotDone = 0; prevSbit = 1'b0;
        while (cyc < 60 && !gotDone) begin
            hold = (idx == holdAt && held < holdLen);
            if (hold) held++;
            @(negedge clk);
            checkOutput({name, " ready_low"}, 32'(in_ready), 32'd0);
            if (done) begin
                gotDone = 1;
                checkOutput({name, " done_cycle"}, 32'(cyc), 32'(17 + holdLen));
                checkOutput({name, " busy_in_done"}, 32'(busy), 32'd0);
            end else if (hold) begin
                checkOutput({name, " held_strobes"}, {30'd0, sr, sl}, 32'd0);
                checkOutput({name, " held_sbit"}, 32'(sbit), 32'(prevSbit));
            end else begin
                checkOutput({name, " busy"}, 32'(busy), 32'd1);
                checkOutput({name, " strobe_dir"}, {30'd0, sr, sl}, d ? 32'd1 : 32'd2);
                if (idx < 16) begin
                    checkOutput({name, " sbit"}, 32'(sbit), 32'(expSeq[idx]));
                end else begin
                    checkOutput({name, " extra_strobe"}, 32'(idx), 32'd15);
                end
                prevSbit = sbit;
                idx++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        hold = 1'b0;
        checkOutput({name, " done_seen"}, 32'(gotDone), 32'd1);
        checkOutput({name, " strobe_count"}, 32'(idx), 32'd16);
        checkOutput({name, " loopback"}, 32'(rx), 32'(expRx));
        @(negedge clk);
        checkOutput({name, " ready_after"}, 32'(in_ready), 32'd1);
        checkOutput({name, " done_single"}, 32'(done), 32'd0);
    endtask

    // Watch a window of cycles and require that done never pulses.
    task automatic expectNoDone(input string name, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        checkOutput(name, 32'(seen), 32'd0);
    endtask

    // Test sequence.
    initial begin
        int accCyc[2];
        int nAcc;
        int nDone;

        checks = 0;
        fails  = 0;
        vecs[0] = '{16'hA5C3, 1'b0, 16'hA5C3, 16'hA5C3, "right_A5C3"};
        vecs[1] = '{16'h8001, 1'b1, 16'h8001, 16'h8001, "left_8001"};
        vecs[2] = '{16'h1234, 1'b1, 16'h2C48, 16'h1234, "left_1234"};
        vecs[3] = '{16'h00FF, 1'b0, 16'h00FF, 16'h00FF, "right_00FF"};
        vecs[4] = '{16'hF0F0, 1'b1, 16'h0F0F, 16'hF0F0, "left_F0F0"};

        rst_n = 1'b0; cl = 1'b0; hold = 1'b0;
        applyStimulus(16'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_outputs", {27'd0, sbit, sr, sl, busy, done}, 32'd0);
        checkOutput("reset_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            runTransfer(vecs[v].word, vecs[v].d, -1, 0, vecs[v].expSeq, vecs[v].expRx, vecs[v].name);
        end

        // Hold for three cycles after the fifth strobe.
        runTransfer(16'hA5C3, 1'b0, 5, 3, 16'hA5C3, 16'hA5C3, "hold_right");
        runTransfer(16'h1234, 1'b1, 5, 3, 16'h2C48, 16'h1234, "hold_left");

        // Back-to-back words with valid held high.
        @(posedge clk); #1;
        applyStimulus(16'h1234, 1'b0, 1'b1);
        nAcc = 0; nDone = 0; accCyc[0] = 0; accCyc[1] = 0;
        for (int c = 0; c < 60 && nDone < 2; c++) begin
            @(negedge clk);
            if (in_ready && in_valid && nAcc < 2) begin
                accCyc[nAcc] = c;
                nAcc++;
            end
            if (done) begin
                checkOutput("b2b_loopback", 32'(rx), nDone == 0 ? 32'h1234 : 32'hFFFF);
                nDone++;
            end
            @(posedge clk); #1;
            if (nAcc == 1) in = 16'hFFFF;
            if (nAcc == 2) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        checkOutput("b2b_accepts", 32'(nAcc), 32'd2);
        checkOutput("b2b_dones", 32'(nDone), 32'd2);
        checkOutput("b2b_period", 32'(accCyc[1] - accCyc[0]), 32'd18);

        // Abort on the cycle of the eighth strobe.
        @(posedge clk); #1;
        applyStimulus(16'hFFFF, 1'b0, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        cl = 1'b1;
        @(negedge clk);
        checkOutput("cl_no_strobe", {30'd0, sr, sl}, 32'd0);
        @(posedge clk); #1;
        cl = 1'b0;
        @(negedge clk);
        checkOutput("cl_idle_ready", 32'(in_ready), 32'd1);
        checkOutput("cl_idle_busy", 32'(busy), 32'd0);
        expectNoDone("cl_no_done", 20);
        runTransfer(16'h00FF, 1'b0, -1, 0, 16'h00FF, 16'h00FF, "after_cl");

        // Asynchronous reset on the cycle of the fourth strobe.
        @(posedge clk); #1;
        applyStimulus(16'hFFFF, 1'b1, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_outputs", {27'd0, sbit, sr, sl, busy, done}, 32'd0);
        checkOutput("arst_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("arst_ready_after", 32'(in_ready), 32'd1);
        checkOutput("arst_busy_after", 32'(busy), 32'd0);
        expectNoDone("arst_no_done", 20);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_shift_serializer
